// File: rtl/nv_nvdla_pdp_split_sched.sv
// Split-width operation scheduler for the PDP core.
// Starts each operation, walks nested width/height/surface/segment counters
// for input (RDMA->core) and output (core->WDMA) beats, picks the per-segment
// widths and holds input of segment k+1 until segment k output has drained.
module nv_nvdla_pdp_split_sched (
  input  logic        nvdla_core_clk,
  input  logic        nvdla_core_rstn,
  input  logic        reg2dp_op_en,
  input  logic [7:0]  pooling_splitw_num_cfg,
  input  logic [9:0]  pooling_fwidth_cfg,
  input  logic [9:0]  pooling_mwidth_cfg,
  input  logic [9:0]  pooling_lwidth_cfg,
  input  logic [9:0]  pooling_out_fwidth_cfg,
  input  logic [9:0]  pooling_out_mwidth_cfg,
  input  logic [9:0]  pooling_out_lwidth_cfg,
  input  logic [12:0] reg2dp_cube_in_height,
  input  logic [12:0] reg2dp_cube_out_height,
  input  logic [12:0] pooling_channel_cfg,
  input  logic        in_valid,
  input  logic        in_ready_core,
  output logic        in_ready,
  input  logic        out_valid,
  input  logic        out_ready,
  output logic        pdp_op_start,
  output logic [7:0]  seg_idx,
  output logic [9:0]  seg_width_in,
  output logic [9:0]  seg_width_out,
  output logic        in_line_end,
  output logic        in_surf_end,
  output logic        in_seg_end,
  output logic        sched_busy,
  output logic        dp2reg_done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t      r_state;
  logic        r_op_en_d;
  logic        r_op_start;
  logic        r_done;
  logic        r_busy;

  logic [9:0]  r_in_w;
  logic [12:0] r_in_h;
  logic [12:0] r_in_c;
  logic [7:0]  r_in_seg;
  logic [9:0]  r_out_w;
  logic [12:0] r_out_h;
  logic [12:0] r_out_c;
  logic [7:0]  r_out_seg;

  logic        w_in_acc;
  logic        w_out_acc;
  logic        w_in_line_end;
  logic        w_in_surf_end;
  logic        w_in_seg_end;
  logic        w_out_line_end;
  logic        w_out_surf_end;
  logic        w_out_seg_end;
  logic        w_seg_drained;
  logic        w_last_seg;
  logic        w_abort;
  logic        w_clear;
  logic [9:0]  w_width_in;
  logic [9:0]  w_width_out;

  // First segment (or an unsplit op) uses fwidth, the final one lwidth, the rest mwidth.
  function automatic logic [9:0] selWidth(input logic [7:0] seg, input logic [7:0] num,
                                          input logic [9:0] fw, input logic [9:0] mw,
                                          input logic [9:0] lw);
    logic [9:0] w;
    if (num == 8'd0 || seg == 8'd0) w = fw;
    else if (seg == num)            w = lw;
    else                            w = mw;
    return w;
  endfunction

  assign w_width_in  = selWidth(r_in_seg, pooling_splitw_num_cfg, pooling_fwidth_cfg,
                                pooling_mwidth_cfg, pooling_lwidth_cfg);
  assign w_width_out = selWidth(r_out_seg, pooling_splitw_num_cfg, pooling_out_fwidth_cfg,
                                pooling_out_mwidth_cfg, pooling_out_lwidth_cfg);

  assign in_ready  = in_ready_core & (r_state == S_RUN);
  assign w_in_acc  = in_valid & in_ready;
  assign w_out_acc = out_valid & out_ready & (r_state != S_IDLE);

  assign w_in_line_end  = (r_in_w == w_width_in);
  assign w_in_surf_end  = w_in_line_end & (r_in_h == reg2dp_cube_in_height);
  assign w_in_seg_end   = w_in_surf_end & (r_in_c == pooling_channel_cfg);
  assign w_out_line_end = (r_out_w == w_width_out);
  assign w_out_surf_end = w_out_line_end & (r_out_h == reg2dp_cube_out_height);
  assign w_out_seg_end  = w_out_surf_end & (r_out_c == pooling_channel_cfg);

  // The output side only releases input once it finishes the segment input is parked on.
  assign w_seg_drained = w_out_acc & w_out_seg_end & (r_out_seg == r_in_seg);
  assign w_last_seg    = (r_in_seg == pooling_splitw_num_cfg);

  assign w_abort = ~reg2dp_op_en &
                   ((r_state == S_START) | (r_state == S_RUN) | (r_state == S_DRAIN));
  assign w_clear = w_abort | ~((r_state == S_RUN) | (r_state == S_DRAIN));

  assign in_line_end   = w_in_line_end;
  assign in_surf_end   = w_in_surf_end;
  assign in_seg_end    = w_in_seg_end;
  assign seg_idx       = r_in_seg;
  assign seg_width_in  = w_width_in;
  assign seg_width_out = w_width_out;
  assign pdp_op_start  = r_op_start;
  assign dp2reg_done   = r_done;
  assign sched_busy    = r_busy;

  // Operation state machine with registered start/done pulses and busy flag.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_state    <= S_IDLE;
      r_op_en_d  <= 1'b0;
      r_op_start <= 1'b0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_op_en_d  <= reg2dp_op_en;
      r_op_start <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (reg2dp_op_en && !r_op_en_d) begin
            r_state    <= S_START;
            r_op_start <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        S_START: begin
          if (w_abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (w_in_acc && w_in_seg_end) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (w_seg_drained) begin
            if (w_last_seg) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_RUN;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Nested beat counters; the input segment index only advances once its output has drained.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_in_w    <= 10'd0;
      r_in_h    <= 13'd0;
      r_in_c    <= 13'd0;
      r_in_seg  <= 8'd0;
      r_out_w   <= 10'd0;
      r_out_h   <= 13'd0;
      r_out_c   <= 13'd0;
      r_out_seg <= 8'd0;
    end else if (w_clear) begin
      r_in_w    <= 10'd0;
      r_in_h    <= 13'd0;
      r_in_c    <= 13'd0;
      r_in_seg  <= 8'd0;
      r_out_w   <= 10'd0;
      r_out_h   <= 13'd0;
      r_out_c   <= 13'd0;
      r_out_seg <= 8'd0;
    end else begin
      if (w_in_acc) begin
        if (w_in_line_end) begin
          r_in_w <= 10'd0;
          if (w_in_surf_end) begin
            r_in_h <= 13'd0;
            if (w_in_seg_end) r_in_c <= 13'd0;
            else              r_in_c <= r_in_c + 13'd1;
          end else begin
            r_in_h <= r_in_h + 13'd1;
          end
        end else begin
          r_in_w <= r_in_w + 10'd1;
        end
      end
      if (r_state == S_DRAIN && w_seg_drained && !w_last_seg) begin
        r_in_seg <= r_in_seg + 8'd1;
      end
      if (w_out_acc) begin
        if (w_out_line_end) begin
          r_out_w <= 10'd0;
          if (w_out_surf_end) begin
            r_out_h <= 13'd0;
            if (w_out_seg_end) begin
              r_out_c <= 13'd0;
              if (r_out_seg == pooling_splitw_num_cfg) r_out_seg <= 8'd0;
              else                                     r_out_seg <= r_out_seg + 8'd1;
            end else begin
              r_out_c <= r_out_c + 13'd1;
            end
          end else begin
            r_out_h <= r_out_h + 13'd1;
          end
        end else begin
          r_out_w <= r_out_w + 10'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_nv_nvdla_pdp_split_sched.sv
// Scoreboard bench for nv_nvdla_pdp_split_sched: the expected per-beat
// responses of each operation are queued up front from nested loops over the
// configuration, and a negedge monitor pops and compares as beats are accepted.
module tb_nv_nvdla_pdp_split_sched;

  logic        clock;
  logic        rstN;
  logic        reg2dp_op_en;
  logic [7:0]  cfgSplit;
  logic [9:0]  cfgFw, cfgMw, cfgLw, cfgOfw, cfgOmw, cfgOlw;
  logic [12:0] cfgInH, cfgOutH, cfgCh;
  logic        in_valid, in_ready_core, in_ready, out_valid, out_ready;
  logic        pdp_op_start, in_line_end, in_surf_end, in_seg_end, sched_busy, dp2reg_done;
  logic [7:0]  seg_idx;
  logic [9:0]  seg_width_in, seg_width_out;

  typedef struct {
    logic [7:0] seg;
    logic [9:0] w;
    logic       le;
    logic       se;
    logic       ge;
    int         outBeats;
  } inExp_t;

  typedef struct {
    logic [9:0] w;
    bit         segLast;
    bit         opLast;
  } outExp_t;

  inExp_t  inQ[$];
  outExp_t outQ[$];
  inExp_t  inE;
  outExp_t outE;

  int testCount = 0;
  int failCount = 0;
  int cycCount = 0;
  int inAccCount = 0;
  int outAccCount = 0;
  int startCount = 0;
  int doneCount = 0;
  int outCredit = 0;
  int seg0EndCyc = 0;
  int expInTotal = 0;
  int expOutTotal = 0;
  bit checkOn = 0;
  bit stallMode = 0;
  bit seg0Ended = 0;
  bit drainWin = 0;
  bit expRise = 0;
  bit doneExp = 0;
  bit busyFallExp = 0;

  nv_nvdla_pdp_split_sched dut (
    .nvdla_core_clk         (clock),
    .nvdla_core_rstn        (rstN),
    .reg2dp_op_en           (reg2dp_op_en),
    .pooling_splitw_num_cfg (cfgSplit),
    .pooling_fwidth_cfg     (cfgFw),
    .pooling_mwidth_cfg     (cfgMw),
    .pooling_lwidth_cfg     (cfgLw),
    .pooling_out_fwidth_cfg (cfgOfw),
    .pooling_out_mwidth_cfg (cfgOmw),
    .pooling_out_lwidth_cfg (cfgOlw),
    .reg2dp_cube_in_height  (cfgInH),
    .reg2dp_cube_out_height (cfgOutH),
    .pooling_channel_cfg    (cfgCh),
    .in_valid               (in_valid),
    .in_ready_core          (in_ready_core),
    .in_ready               (in_ready),
    .out_valid              (out_valid),
    .out_ready              (out_ready),
    .pdp_op_start           (pdp_op_start),
    .seg_idx                (seg_idx),
    .seg_width_in           (seg_width_in),
    .seg_width_out          (seg_width_out),
    .in_line_end            (in_line_end),
    .in_surf_end            (in_surf_end),
    .in_seg_end             (in_seg_end),
    .sched_busy             (sched_busy),
    .dp2reg_done            (dp2reg_done)
  );

  // Free-running core clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int selW(input int s, input int n, input int f, input int m, input int l);
    if (n == 0 || s == 0) return f;
    if (s == n) return l;
    return m;
  endfunction

  // Reference model: enumerate every beat of the operation in order.
  task automatic buildExpect();
    int n, wi, wo, ob;
    inExp_t e;
    outExp_t o;
    n = int'(cfgSplit);
    expInTotal = 0;
    expOutTotal = 0;
    for (int s = 0; s <= n; s++) begin
      wi = selW(s, n, int'(cfgFw), int'(cfgMw), int'(cfgLw));
      wo = selW(s, n, int'(cfgOfw), int'(cfgOmw), int'(cfgOlw));
      ob = (wo + 1) * (int'(cfgOutH) + 1) * (int'(cfgCh) + 1);
      for (int c = 0; c <= int'(cfgCh); c++)
        for (int h = 0; h <= int'(cfgInH); h++)
          for (int w = 0; w <= wi; w++) begin
            e.seg = 8'(s);
            e.w = 10'(wi);
            e.le = (w == wi);
            e.se = e.le && (h == int'(cfgInH));
            e.ge = e.se && (c == int'(cfgCh));
            e.outBeats = ob;
            inQ.push_back(e);
            expInTotal++;
          end
      for (int b = 0; b < ob; b++) begin
        o.w = 10'(wo);
        o.segLast = (b == ob - 1);
        o.opLast = (b == ob - 1) && (s == n);
        outQ.push_back(o);
        expOutTotal++;
      end
    end
  endtask

  // Monitor: pops the scoreboard on every accepted beat and tracks drain/done timing.
  always @(negedge clock) begin
    cycCount++;
    if (!rstN || !checkOn) begin
      inQ.delete();
      outQ.delete();
      outCredit = 0;
      drainWin = 0;
      expRise = 0;
      doneExp = 0;
      busyFallExp = 0;
      seg0Ended = 0;
    end else begin
      if (dp2reg_done || doneExp) checkOutput("donePulse", {31'd0, dp2reg_done}, {31'd0, doneExp});
      if (busyFallExp) checkOutput("busyFall", {31'd0, sched_busy}, 32'd0);
      busyFallExp = doneExp;
      doneExp = 0;
      if (drainWin) checkOutput("drainReadyLow", {31'd0, in_ready}, 32'd0);
      if (expRise) checkOutput("readyRise", {31'd0, in_ready}, {31'd0, in_ready_core});
      expRise = 0;
      if (in_valid && in_ready) begin
        inAccCount++;
        if (inQ.size() == 0) begin
          checkOutput("inExtraBeat", 32'(inAccCount), 32'(inAccCount - 1));
        end else begin
          inE = inQ.pop_front();
          checkOutput("inBeat", {11'd0, seg_idx, seg_width_in, in_line_end, in_surf_end, in_seg_end},
                      {11'd0, inE.seg, inE.w, inE.le, inE.se, inE.ge});
          if (inE.ge) begin
            drainWin = 1;
            outCredit += inE.outBeats;
            if (inE.seg == 8'd0) begin
              seg0Ended = 1;
              seg0EndCyc = cycCount;
            end
          end
        end
      end
      if (out_valid && out_ready) begin
        outAccCount++;
        outCredit--;
        if (outQ.size() == 0) begin
          checkOutput("outExtraBeat", 32'(outAccCount), 32'(outAccCount - 1));
        end else begin
          outE = outQ.pop_front();
          checkOutput("outWidth", {22'd0, seg_width_out}, {22'd0, outE.w});
          if (outE.segLast) begin
            drainWin = 0;
            if (outE.opLast) doneExp = 1;
            else expRise = 1;
          end
        end
      end
    end
    if (rstN && pdp_op_start) startCount++;
    if (rstN && dp2reg_done) doneCount++;
  end

  task automatic driveIdle();
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    out_valid = 1'b0;
    in_ready_core = 1'b1;
    out_ready = 1'b1;
  endtask

  task automatic driveCycle(input int pct);
    @(posedge clock);
    #1;
    in_valid = ($urandom_range(1, 100) <= pct);
    in_ready_core = ($urandom_range(1, 100) <= pct);
    out_valid = (outCredit > 0) && ($urandom_range(1, 100) <= pct);
    out_ready = ($urandom_range(1, 100) <= pct);
    if (stallMode && seg0Ended && (cycCount - seg0EndCyc) < 20) out_ready = 1'b0;
  endtask

  task automatic setCfg(input int sp, input int fw, input int mw, input int lw,
                        input int ofw, input int omw, input int olw,
                        input int ih, input int oh, input int ch);
    cfgSplit = 8'(sp);
    cfgFw = 10'(fw);
    cfgMw = 10'(mw);
    cfgLw = 10'(lw);
    cfgOfw = 10'(ofw);
    cfgOmw = 10'(omw);
    cfgOlw = 10'(olw);
    cfgInH = 13'(ih);
    cfgOutH = 13'(oh);
    cfgCh = 13'(ch);
  endtask

  // One operation: queue expectations, pulse op_en, run to done/abort/reset.
  task automatic applyStimulus(input int pct, input bit stall, input int abortAt, input bit resetInDrain);
    int inBase, outBase, startBase, doneBase, budget;
    bit ended;
    checkOn = 0;
    driveIdle();
    checkOn = 1;
    buildExpect();
    inBase = inAccCount;
    outBase = outAccCount;
    startBase = startCount;
    doneBase = doneCount;
    stallMode = stall;
    reg2dp_op_en = 1'b1;
    @(negedge clock);
    checkOutput("startNotEarly", {31'd0, pdp_op_start}, 32'd0);
    driveCycle(pct);
    @(negedge clock);
    checkOutput("startPulse", {31'd0, pdp_op_start}, 32'd1);
    ended = 0;
    budget = 20000;
    while (!ended && budget > 0) begin
      driveCycle(pct);
      budget--;
      if (doneCount > doneBase) ended = 1;
      if (abortAt > 0 && (inAccCount - inBase) >= abortAt) ended = 1;
      if (resetInDrain && drainWin && seg0Ended && (cycCount - seg0EndCyc) >= 3) ended = 1;
    end
    checkOutput("opReachedEnd", {31'd0, ended}, 32'd1);
    if (abortAt > 0) begin
      reg2dp_op_en = 1'b0;
      in_valid = 1'b0;
      out_valid = 1'b0;
      driveIdle();
      @(negedge clock);
      checkOutput("abortBusy", {31'd0, sched_busy}, 32'd0);
      checkOutput("abortSegIdx", {24'd0, seg_idx}, 32'd0);
      checkOutput("abortReady", {31'd0, in_ready}, 32'd0);
      repeat (6) driveIdle();
      checkOutput("abortNoDone", 32'(doneCount - doneBase), 32'd0);
      checkOutput("abortBeats", 32'(inAccCount - inBase), 32'(abortAt));
    end else if (resetInDrain) begin
      #2;
      rstN = 1'b0;
      reg2dp_op_en = 1'b0;
      #1;
      checkOutput("rstStart", {31'd0, pdp_op_start}, 32'd0);
      checkOutput("rstDone", {31'd0, dp2reg_done}, 32'd0);
      checkOutput("rstBusy", {31'd0, sched_busy}, 32'd0);
      checkOutput("rstReady", {31'd0, in_ready}, 32'd0);
      checkOutput("rstSegIdx", {24'd0, seg_idx}, 32'd0);
      checkOutput("rstWidthIn", {22'd0, seg_width_in}, {22'd0, cfgFw});
      checkOutput("rstWidthOut", {22'd0, seg_width_out}, {22'd0, cfgOfw});
      repeat (2) driveIdle();
      rstN = 1'b1;
      repeat (10) driveIdle();
      checkOutput("postRstNoDone", 32'(doneCount - doneBase), 32'd0);
      checkOutput("postRstNoStart", 32'(startCount - startBase), 32'd1);
    end else begin
      reg2dp_op_en = 1'b0;
      repeat (3) driveIdle();
      checkOutput("startCount", 32'(startCount - startBase), 32'd1);
      checkOutput("doneCount", 32'(doneCount - doneBase), 32'd1);
      checkOutput("inBeatTotal", 32'(inAccCount - inBase), 32'(expInTotal));
      checkOutput("outBeatTotal", 32'(outAccCount - outBase), 32'(expOutTotal));
      checkOutput("inQueueEmpty", 32'(inQ.size()), 32'd0);
      checkOutput("outQueueEmpty", 32'(outQ.size()), 32'd0);
      checkOutput("idleBusy", {31'd0, sched_busy}, 32'd0);
    end
    stallMode = 0;
  endtask

  // Test sequence.
  initial begin
    rstN = 1'b0;
    reg2dp_op_en = 1'b0;
    in_valid = 1'b0;
    in_ready_core = 1'b1;
    out_valid = 1'b0;
    out_ready = 1'b1;
    setCfg(0, 3, 0, 0, 1, 0, 0, 1, 0, 0);
    repeat (3) @(posedge clock);
    #1;
    checkOutput("resetStart", {31'd0, pdp_op_start}, 32'd0);
    checkOutput("resetDone", {31'd0, dp2reg_done}, 32'd0);
    checkOutput("resetBusy", {31'd0, sched_busy}, 32'd0);
    checkOutput("resetReady", {31'd0, in_ready}, 32'd0);
    checkOutput("resetSegIdx", {24'd0, seg_idx}, 32'd0);
    checkOutput("resetWidthIn", {22'd0, seg_width_in}, {22'd0, cfgFw});
    checkOutput("resetWidthOut", {22'd0, seg_width_out}, {22'd0, cfgOfw});
    rstN = 1'b1;
    repeat (2) driveIdle();

    // unsplit op, continuous handshakes
    applyStimulus(100, 0, 0, 0);
    // three segments, widths 2/4/1
    setCfg(2, 2, 4, 1, 1, 2, 0, 0, 0, 0);
    applyStimulus(100, 0, 0, 0);
    // output stalled 20 cycles after segment 0 input ends
    applyStimulus(100, 1, 0, 0);
    // abort after 5 input beats, then restart cleanly
    setCfg(0, 3, 0, 0, 1, 0, 0, 1, 0, 0);
    applyStimulus(100, 0, 5, 0);
    applyStimulus(100, 0, 0, 0);
    // asynchronous reset while draining segment 0
    setCfg(2, 2, 4, 1, 1, 2, 0, 0, 0, 0);
    applyStimulus(100, 1, 0, 1);
    // randomized backpressure with five segments and four surfaces
    for (int k = 0; k < 3; k++) begin
      setCfg(4, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
             int'($urandom_range(0, 2)), int'($urandom_range(0, 1)), 3);
      applyStimulus(60, 0, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
